regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the dual-issue MIPS core, successor to the single-write, two-read register file. It serves NREAD read ports and NWRITE write-back ports in one cycle, forwards same-cycle writes to readers, and keeps a per-register busy scoreboard. Issue logic uses the scoreboard to stall RAW hazards; exceptions use it to flush. It sits between decode/issue (read and issue side) and write-back (write side).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NREAD, 4, number of read ports
- NWRITE, 2, number of write-back ports; a higher index is later in program order
- BYPASS, 1, 1 forwards same-cycle write data to readers, 0 reads the array only

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  NWRITE  write enable per write port
- waddr  in  NWRITE*ADDR_W  write addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- wdata  in  NWRITE*DATA_W  write data, packed the same way
- raddr  in  NREAD*ADDR_W  read addresses, packed
- rdata  out  NREAD*DATA_W  read data, combinational
- rbusy  out  NREAD  busy bit of each read address after write-back clearing, combinational
- issue_en  in  NWRITE  marks an issued instruction's destination as pending
- issue_addr  in  NWRITE*ADDR_W  destination addresses to mark pending
- flush  in  1  synchronous clear of all busy bits
- busy_cnt  out  ADDR_W+1  registered count of busy registers

## Operation
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues targeting register 0 are ignored.
- Write:
  - At the rising edge, regs[waddr[k]] <= wdata[k] for each port with we[k]=1.
  - If several ports write the same address, the highest k wins.
- Read, port i, evaluated in priority order:
  - raddr=0 gives 0.
  - If BYPASS=1 and some we[k] has waddr[k]==raddr, the result is wdata of the highest such k.
  - Otherwise the result is regs[raddr].
- rbusy[i] = busy[raddr[i]] & ~(any we[k] with waddr[k]==raddr[i]). Forwarded data is therefore never flagged busy.
  - When BYPASS=0, rbusy[i] = busy[raddr[i]]; the write-back clear is not applied.
- Scoreboard update per register r at the edge, in priority order:
  1. flush: busy[r] <= 0, and all issues this cycle are dropped.
  2. Any issue_en[k] with issue_addr[k]==r: busy[r] <= 1. A new producer overrides a write-back clear.
  3. Any we[k] with waddr[k]==r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- busy_cnt is the popcount of the busy vector after the update, registered, so it is valid one cycle after the edge.

## Timing
- While rst=0:
  - All registers are 0, all busy bits are 0, busy_cnt is 0.
  - Writes, issues and bypass are suppressed, so rdata=0 and rbusy=0.
- Reset asserted mid-operation clears state immediately and asynchronously. No pending write completes.
- Read latency is 0 cycles, combinational from raddr/we/waddr/wdata.
- Write-to-array latency is 1 edge. With BYPASS=0, a reader sees new data the cycle after the write.
- Issue-to-busy latency is 1 edge. rbusy reflects an issue from the next cycle onward.
- busy_cnt can reach 2**ADDR_W-1 (all but register 0); its width covers 2**ADDR_W.

## Structure
- Shared package regfile_pkg holds:
  - DATA_W, ADDR_W, NREAD and NWRITE defaults.
  - A function priority_match(addr, we, waddr) that returns a hit flag and the winning port index. Both the bypass path and the scoreboard use it.
- Sub-module regfile_scoreboard (busy vector, flush, issue/clear priority, busy_cnt) is instantiated once. The data array, write logic and bypass stay in regfile_mp.

## Test plan
- Reset, then write 0x12345678 to r5 on port 0. After the edge, raddr0=5 -> rdata0=0x12345678, rbusy0=0.
- Same cycle: port 0 writes r7=0xAAAA0000, port 1 writes r7=0x0000BBBB, raddr1=7. Same cycle -> rdata1=0x0000BBBB (bypass). Next cycle -> 0x0000BBBB from the array. With BYPASS=0, the same-cycle read returns the old value.
- Write 0xFFFFFFFF to r0 with raddr2=0 -> rdata2=0 in that cycle and after. Issue r0 -> busy_cnt stays 0.
- Issue r3 -> next cycle rbusy=1, busy_cnt=1.
  - Write-back r3 while issuing r3 again in the same cycle -> busy stays 1.
  - Write-back r3 alone -> rbusy=0 in that same cycle (forwarded); busy_cnt=0 after the edge.
- Issue r4 and r9. Next cycle, assert flush together with issue r10 -> after the edge all busy bits are 0 and busy_cnt=0.
- Fill registers, then pulse rst low between edges -> rdata and rbusy are 0 immediately. After release, all registers read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the write-port match helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefAddrW  = 5;
  localparam int unsigned DefNRead  = 4;
  localparam int unsigned DefNWrite = 2;

  // Port vectors are widened to these maxima before calling priority_match.
  localparam int unsigned MaxWrite = 8;
  localparam int unsigned MaxAddrW = 8;
  localparam int unsigned IdxW     = 3;

  typedef struct packed {
    logic            hit;
    logic [IdxW-1:0] idx;
  } match_t;

  // Highest-index enabled port whose address equals addr; a miss returns all zeros.
  function automatic match_t priority_match(input logic [MaxAddrW-1:0]          addr,
                                            input logic [MaxWrite-1:0]          en,
                                            input logic [MaxWrite*MaxAddrW-1:0] addrs);
    match_t m;
    m = '0;
    for (int k = 0; k < MaxWrite; k++) begin
      if (en[k] && (addrs[k*MaxAddrW +: MaxAddrW] == addr)) begin
        m.hit = 1'b1;
        m.idx = IdxW'(k);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: flush beats issue, issue beats write-back clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [MaxWrite-1:0]          we_i,
  input  logic [MaxWrite*MaxAddrW-1:0] waddr_i,
  input  logic [MaxWrite-1:0]          issue_en_i,
  input  logic [MaxWrite*MaxAddrW-1:0] issue_addr_i,
  input  logic                         flush_i,
  output logic [2**ADDR_W-1:0]         busy_o,
  output logic [ADDR_W:0]              busy_cnt_o
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [Depth-1:0] busy_d, busy_q;
  logic [ADDR_W:0]  cnt_d, cnt_q;
  match_t           iss_m, wb_m;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    iss_m  = '0;
    wb_m   = '0;
    for (int r = 1; r < Depth; r++) begin
      iss_m = priority_match(MaxAddrW'(r), issue_en_i, issue_addr_i);
      wb_m  = priority_match(MaxAddrW'(r), we_i, waddr_i);
      // A miss is all zeros, so a non-zero result is a hit.
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (iss_m != '0) begin
        busy_d[r] = 1'b1;
      end else if (wb_m != '0) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
    for (int r = 0; r < Depth; r++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write forwarding and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NREAD  = DefNRead,
  parameter int unsigned NWRITE = DefNWrite,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NWRITE-1:0]        issue_en,
  input  logic [NWRITE*ADDR_W-1:0] issue_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [DATA_W-1:0]            regs_d [Depth];
  logic [DATA_W-1:0]            regs_q [Depth];
  logic [Depth-1:0]             busy;
  logic [MaxWrite-1:0]          we_w, iss_w;
  logic [MaxWrite*MaxAddrW-1:0] waddr_w, iss_addr_w;
  logic [ADDR_W-1:0]            rd_addr;
  match_t                       rd_m;

  // Widen to the helper's fixed port shape; enables are masked while in reset.
  always_comb begin
    we_w       = '0;
    iss_w      = '0;
    waddr_w    = '0;
    iss_addr_w = '0;
    for (int k = 0; k < NWRITE; k++) begin
      we_w[k]  = we[k] & rst;
      iss_w[k] = issue_en[k] & rst;
      waddr_w[k*MaxAddrW +: MaxAddrW]    = MaxAddrW'(waddr[k*ADDR_W +: ADDR_W]);
      iss_addr_w[k*MaxAddrW +: MaxAddrW] = MaxAddrW'(issue_addr[k*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0)) begin
        regs_d[waddr[k*ADDR_W +: ADDR_W]] = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < Depth; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata   = '0;
    rbusy   = '0;
    rd_addr = '0;
    rd_m    = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_addr = raddr[i*ADDR_W +: ADDR_W];
      rd_m    = priority_match(MaxAddrW'(rd_addr), we_w, waddr_w);
      if (!rst || (rd_addr == '0)) begin
        rdata[i*DATA_W +: DATA_W] = '0;
      end else if (BYPASS && rd_m.hit) begin
        rdata[i*DATA_W +: DATA_W] = wdata[rd_m.idx*DATA_W +: DATA_W];
      end else begin
        rdata[i*DATA_W +: DATA_W] = regs_q[rd_addr];
      end
      // Forwarded data is never reported busy.
      rbusy[i] = rst & busy[rd_addr] & ~(BYPASS & rd_m.hit);
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (rst),
    .we_i         (we_w),
    .waddr_i      (waddr_w),
    .issue_en_i   (iss_w),
    .issue_addr_i (iss_addr_w),
    .flush_i      (flush),
    .busy_o       (busy),
    .busy_cnt_o   (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus and one reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata, rdata_nb;
  logic [NR-1:0]    rbusy, rbusy_nb;
  logic [NW-1:0]    issue_en;
  logic [NW*AW-1:0] issue_addr;
  logic             flush;
  logic [AW:0]      busy_cnt, busy_cnt_nb;

  int tests = 0;
  int fails = 0;

  logic [31:0] mregs [32];
  bit          mbusy [32];
  int          mcnt;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W (DW), .ADDR_W (AW), .NREAD (NR), .NWRITE (NW), .BYPASS (1'b1)
  ) u_dut (
    .clk (clk), .rst (rst), .we (we), .waddr (waddr), .wdata (wdata), .raddr (raddr),
    .rdata (rdata), .rbusy (rbusy), .issue_en (issue_en), .issue_addr (issue_addr),
    .flush (flush), .busy_cnt (busy_cnt)
  );

  regfile_mp #(
    .DATA_W (DW), .ADDR_W (AW), .NREAD (NR), .NWRITE (NW), .BYPASS (1'b0)
  ) u_dut_nb (
    .clk (clk), .rst (rst), .we (we), .waddr (waddr), .wdata (wdata), .raddr (raddr),
    .rdata (rdata_nb), .rbusy (rbusy_nb), .issue_en (issue_en), .issue_addr (issue_addr),
    .flush (flush), .busy_cnt (busy_cnt_nb)
  );

  function automatic logic [4:0] wa(input int k);
    return waddr[k*AW +: AW];
  endfunction

  function automatic logic [31:0] wd(input int k);
    return wdata[k*DW +: DW];
  endfunction

  function automatic logic [4:0] rda(input int i);
    return raddr[i*AW +: AW];
  endfunction

  function automatic logic [31:0] rd(input logic [NR*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Expected read: the latest same-cycle writer to the address, else the stored value.
  function automatic logic [31:0] exp_rdata(input int i, input bit byp);
    logic [4:0] a;
    a = rda(i);
    if (!rst || a == 5'd0) return 32'd0;
    if (byp) begin
      for (int k = NW - 1; k >= 0; k--) begin
        if (we[k] && wa(k) == a) return wd(k);
      end
    end
    return mregs[a];
  endfunction

  function automatic logic [31:0] exp_rbusy(input int i, input bit byp);
    logic [4:0] a;
    a = rda(i);
    if (!rst) return 32'd0;
    if (byp) begin
      for (int k = 0; k < NW; k++) begin
        if (we[k] && wa(k) == a) return 32'd0;
      end
    end
    return {31'd0, mbusy[a]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: write-backs clear, then issues set, flush wipes everything.
  always @(posedge clk or negedge rst) begin
    bit          nb [32];
    logic [31:0] nr [32];
    int          cnt;
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        mregs[r] <= 32'd0;
        mbusy[r] <= 1'b0;
      end
      mcnt <= 0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        nb[r] = mbusy[r];
        nr[r] = mregs[r];
      end
      if (flush) begin
        for (int r = 0; r < 32; r++) nb[r] = 1'b0;
      end else begin
        for (int k = 0; k < NW; k++) if (we[k]) nb[wa(k)] = 1'b0;
        for (int k = 0; k < NW; k++) if (issue_en[k]) nb[issue_addr[k*AW +: AW]] = 1'b1;
      end
      nb[0] = 1'b0;
      for (int k = 0; k < NW; k++) if (we[k] && wa(k) != 5'd0) nr[wa(k)] = wd(k);
      cnt = 0;
      for (int r = 0; r < 32; r++) begin
        if (nb[r]) cnt++;
        mbusy[r] <= nb[r];
        mregs[r] <= nr[r];
      end
      mcnt <= cnt;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      chk("rdata_byp", rd(rdata, i), exp_rdata(i, 1'b1));
      chk("rdata_nobyp", rd(rdata_nb, i), exp_rdata(i, 1'b0));
      chk("rbusy_byp", {31'd0, rbusy[i]}, exp_rbusy(i, 1'b1));
      chk("rbusy_nobyp", {31'd0, rbusy_nb[i]}, exp_rbusy(i, 1'b0));
    end
    chk("busy_cnt_byp", 32'(busy_cnt), 32'(mcnt));
    chk("busy_cnt_nobyp", 32'(busy_cnt_nb), 32'(mcnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we       = '0;
    issue_en = '0;
    flush    = 1'b0;
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
    we[k]            = 1'b1;
    waddr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic iss(input int k, input logic [4:0] a);
    issue_en[k]            = 1'b1;
    issue_addr[k*AW +: AW] = a;
  endtask

  task automatic rdsel(input int i, input logic [4:0] a);
    raddr[i*AW +: AW] = a;
  endtask

  function automatic logic [4:0] ra();
    if ($urandom % 2 == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 1'b0;
    we = '0; waddr = '0; wdata = '0; raddr = '0;
    issue_en = '0; issue_addr = '0; flush = 1'b0;
    step();
    step();
    wr(0, 5'd5, 32'hDEADBEEF);
    rdsel(1, 5'd5);
    #1;
    chk("rst_no_bypass", rd(rdata, 1), 32'd0);
    chk("rst_cnt", 32'(busy_cnt), 32'd0);
    chk("rst_rbusy", 32'(rbusy), 32'd0);
    step();
    idle();
    rst = 1'b1;
    step();

    wr(0, 5'd5, 32'h12345678);
    rdsel(0, 5'd5);
    step();
    idle();
    #1;
    chk("t1_rdata", rd(rdata, 0), 32'h12345678);
    chk("t1_rbusy", 32'(rbusy[0]), 32'd0);
    chk("t1_model", mregs[5], 32'h12345678);

    wr(0, 5'd7, 32'hAAAA0000);
    wr(1, 5'd7, 32'h0000BBBB);
    rdsel(1, 5'd7);
    #1;
    chk("t2_same_byp", rd(rdata, 1), 32'h0000BBBB);
    chk("t2_same_nobyp", rd(rdata_nb, 1), 32'h00000000);
    step();
    idle();
    #1;
    chk("t2_next_byp", rd(rdata, 1), 32'h0000BBBB);
    chk("t2_next_nobyp", rd(rdata_nb, 1), 32'h0000BBBB);

    wr(0, 5'd0, 32'hFFFFFFFF);
    rdsel(2, 5'd0);
    #1;
    chk("t3_r0_same", rd(rdata, 2), 32'd0);
    step();
    idle();
    #1;
    chk("t3_r0_after", rd(rdata, 2), 32'd0);
    iss(0, 5'd0);
    step();
    idle();
    #1;
    chk("t3_r0_issue_cnt", 32'(busy_cnt), 32'd0);

    iss(0, 5'd3);
    rdsel(3, 5'd3);
    step();
    idle();
    #1;
    chk("t4_rbusy", 32'(rbusy[3]), 32'd1);
    chk("t4_cnt", 32'(busy_cnt), 32'd1);
    wr(0, 5'd3, 32'h00000033);
    iss(1, 5'd3);
    step();
    idle();
    #1;
    chk("t4_reissue_busy", 32'(rbusy[3]), 32'd1);
    chk("t4_reissue_cnt", 32'(busy_cnt), 32'd1);
    wr(0, 5'd3, 32'h00000044);
    #1;
    chk("t4_wb_rbusy_byp", 32'(rbusy[3]), 32'd0);
    chk("t4_wb_rbusy_nobyp", 32'(rbusy_nb[3]), 32'd1);
    chk("t4_wb_rdata", rd(rdata, 3), 32'h00000044);
    step();
    idle();
    #1;
    chk("t4_wb_cnt", 32'(busy_cnt), 32'd0);
    chk("t4_model_cnt", 32'(mcnt), 32'd0);

    iss(0, 5'd4);
    iss(1, 5'd9);
    step();
    idle();
    #1;
    chk("t5_cnt", 32'(busy_cnt), 32'd2);
    flush = 1'b1;
    iss(0, 5'd10);
    step();
    idle();
    rdsel(0, 5'd10);
    rdsel(1, 5'd4);
    #1;
    chk("t5_flush_cnt", 32'(busy_cnt), 32'd0);
    chk("t5_flush_r10", 32'(rbusy[0]), 32'd0);
    chk("t5_flush_r4", 32'(rbusy[1]), 32'd0);

    repeat (1500) begin
      idle();
      for (int k = 0; k < NW; k++) begin
        if ($urandom % 3 == 0) wr(k, ra(), $urandom);
        if ($urandom % 3 == 0) iss(k, ra());
      end
      flush = ($urandom % 50 == 0);
      for (int i = 0; i < NR; i++) rdsel(i, ra());
      step();
    end

    for (int r = 1; r < 32; r++) begin
      idle();
      wr(0, 5'(r), $urandom | 32'd1);
      iss(1, 5'(r));
      step();
    end
    idle();
    wr(0, 5'd6, 32'h66666666);
    for (int i = 0; i < NR; i++) rdsel(i, 5'(i + 1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rdata0", rd(rdata, 0), 32'd0);
    chk("t6_rdata3", rd(rdata, 3), 32'd0);
    chk("t6_rbusy", 32'(rbusy), 32'd0);
    chk("t6_cnt", 32'(busy_cnt), 32'd0);
    idle();
    rst = 1'b1;
    step();
    for (int r = 1; r < 32; r += NR) begin
      for (int i = 0; i < NR; i++) rdsel(i, 5'((r + i) % 32));
      #1;
      for (int i = 0; i < NR; i++) begin
        chk("t6_after", rd(rdata_nb, i), 32'd0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
